// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer driver slice.
//
// Contents:
//   NOTE_*      note codes on note_in (0 = rest, 1..7 = do..si, 8..15 = rest)
//   OCT_*       octave codes on octave (3 is played as mid)
//   F_CENTIHZ   mid-octave note frequencies in 1/100 Hz, indexed by note code
//   state_t     tone FSM states
//   mid_half_period()  elaboration-time half-period in clock cycles
//   is_note()          true for a playable note code
package buzzer_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  // Entry 0 stands for the rest code so the table can be indexed directly by note code.
  localparam int unsigned F_CENTIHZ [0:7] = '{
    0, 26163, 29366, 32963, 34923, 39200, 44000, 49388
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TONE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Evaluated only on constants; the 64-bit product avoids overflow of CLK_HZ*100.
  function automatic longint unsigned mid_half_period(
    input longint unsigned clk_hz,
    input logic [2:0]      idx
  );
    return (clk_hz * 64'd100) / (64'd2 * 64'(F_CENTIHZ[idx]));
  endfunction

  function automatic logic is_note(input logic [3:0] code);
    return (code >= NOTE_DO) && (code <= NOTE_SI);
  endfunction

endpackage

// File: rtl/tone_counter.sv
// Half-period counter and square-wave toggle for one buzzer voice.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            start a tone: reload half-period, tone high
//   run             count down; on expiry toggle and reload
//   drain           count down without reloading; on expiry force tone low
//   clear           drop tone and counter immediately
//   note_idx        note code (1..7) whose half-period is used on reload
//   octave          octave code applied to that half-period
//   tone            square-wave output (registered)
//   reload          high in any cycle that reloads the counter
//   last            counter is in the final cycle of its half-period
module tone_counter
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       drain,
  input  logic       clear,
  input  logic [2:0] note_idx,
  input  logic [1:0] octave,
  output logic       tone,
  output logic       reload,
  output logic       last
);

  // Sized for the longest half-period: low-octave do.
  localparam int unsigned CNT_W =
    $clog2(64'd2 * mid_half_period(64'(CLK_HZ), 3'd1) + 64'd1);

  localparam logic [CNT_W-1:0] MID_HP [0:7] = '{
    '0,
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd1)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd2)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd3)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd4)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd5)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd6)),
    CNT_W'(mid_half_period(64'(CLK_HZ), 3'd7))
  };

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] mid_hp;
  logic [CNT_W-1:0] half_period;

  // Octave scaling of the constant mid-octave table; octave code 3 plays as mid.
  always_comb begin
    mid_hp = MID_HP[note_idx];
    case (octave)
      OCT_LOW:  half_period = mid_hp << 1;
      OCT_HIGH: half_period = mid_hp >> 1;
      OCT_MID:  half_period = mid_hp;
      default:  half_period = mid_hp;
    endcase
  end

  // A count of 0 only occurs after a finished drain, so treating it like an
  // expiry lets a returning note restart cleanly without wrapping the counter.
  assign reload = load | (run & (count <= CNT_W'(1)));
  assign last   = (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tone  <= 1'b0;
    end else if (reload) begin
      count <= half_period;
      tone  <= load | ~tone;
    end else if (run) begin
      count <= count - CNT_W'(1);
    end else if (drain) begin
      if (count <= CNT_W'(1)) begin
        count <= '0;
        tone  <= 1'b0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (clear) begin
      count <= '0;
      tone  <= 1'b0;
    end
  end

endmodule

// File: rtl/buzzer_driver.sv
// Square-wave buzzer driver: registers the note request, runs the
// IDLE/TONE/DRAIN sequencer and (optionally) an amplitude envelope.
//
// Build option: define BUZZER_ENVELOPE_EN to add a decaying 8-bit envelope
// applied to the speaker through a free-running PWM comparator.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active-low
//   enable       1 = sound permitted, 0 = forced silence
//   note_in      note code (0 / 8..15 = rest, 1..7 = do..si)
//   octave       0 low, 1 mid, 2 high, 3 mid
//   speaker      buzzer drive
//   playing      high in TONE and DRAIN
//   note_active  note being generated, 0 when silent
module buzzer_driver
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DECAY_CYCLES = 390_625
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave,
  output logic       speaker,
  output logic       playing,
  output logic [3:0] note_active
);

  // A zero decay period has no meaningful step length.
  if (DECAY_CYCLES == 0) begin : g_bad_decay
    $error("buzzer_driver: DECAY_CYCLES must be nonzero");
  end

  state_t     state;
  state_t     next_state;
  logic [3:0] note_reg;
  logic [1:0] octave_reg;
  logic       enable_reg;
  logic       valid;
  logic       load;
  logic       run;
  logic       drain;
  logic       clear;
  logic       tone;
  logic       reload;
  logic       last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_reg   <= '0;
      octave_reg <= '0;
      enable_reg <= 1'b0;
    end else begin
      note_reg   <= note_in;
      octave_reg <= octave;
      enable_reg <= enable;
    end
  end

  assign valid = enable_reg & is_note(note_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // When a rest arrives exactly as a high half ends, go straight to IDLE so
  // speaker and playing fall together instead of lingering a cycle in DRAIN.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    run        = 1'b0;
    drain      = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          load       = 1'b1;
          next_state = ST_TONE;
        end
      end
      ST_TONE: begin
        if (valid) begin
          run = 1'b1;
        end else begin
          drain      = 1'b1;
          next_state = (tone & last) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (valid) begin
          run        = 1'b1;
          next_state = ST_TONE;
        end else if (tone) begin
          drain = 1'b1;
          if (last) begin
            next_state = ST_IDLE;
          end
        end else begin
          clear      = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: begin
        clear      = 1'b1;
        next_state = ST_IDLE;
      end
    endcase
  end

  tone_counter #(
    .CLK_HZ (CLK_HZ)
  ) u_tone (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .run      (run),
    .drain    (drain),
    .clear    (clear),
    .note_idx (note_reg[2:0]),
    .octave   (octave_reg),
    .tone     (tone),
    .reload   (reload),
    .last     (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_active <= NOTE_REST;
    end else if (reload) begin
      note_active <= note_reg;
    end else if (next_state == ST_IDLE) begin
      note_active <= NOTE_REST;
    end
  end

  assign playing = (state != ST_IDLE);

`ifdef BUZZER_ENVELOPE_EN
  localparam int unsigned DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

  logic [7:0]         envelope;
  logic [7:0]         pwm_cnt;
  logic [DECAY_W-1:0] decay_cnt;
  logic               strike;

  // A fresh start or a different note restarts the decay from full scale.
  assign strike = load | (reload & (note_reg != note_active));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      envelope  <= '0;
      decay_cnt <= '0;
    end else if (strike) begin
      envelope  <= 8'hFF;
      decay_cnt <= '0;
    end else if (decay_cnt == DECAY_W'(DECAY_CYCLES - 1)) begin
      decay_cnt <= '0;
      if (envelope != 8'd0) begin
        envelope <= envelope - 8'd1;
      end
    end else begin
      decay_cnt <= decay_cnt + DECAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign speaker = tone & (pwm_cnt < envelope);
`else
  assign speaker = tone;
`endif

endmodule

// File: tb/tb_buzzer_driver.sv
// Self-checking bench for buzzer_driver. Expected half-period lengths are
// pushed to a scoreboard queue as notes are requested and popped as the
// speaker produces each level segment. A reduced CLK_HZ keeps tones short.
module tb_buzzer_driver;

  localparam int unsigned CLK_HZ       = 1_000_000;
  localparam int unsigned DECAY_CYCLES = 4;
  localparam int          SEG_LIMIT    = 10_000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [1:0] octave = 2'd0;
  logic       speaker;
  logic       playing;
  logic [3:0] note_active;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  buzzer_driver #(
    .CLK_HZ       (CLK_HZ),
    .DECAY_CYCLES (DECAY_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .note_in     (note_in),
    .octave      (octave),
    .speaker     (speaker),
    .playing     (playing),
    .note_active (note_active)
  );

  always #5 clk = ~clk;

  // Half-period in cycles from the note frequency table.
  function automatic int tbHalf(input int note, input int oct);
    longint unsigned f;
    longint unsigned mid;
    case (note)
      1: f = 26163;
      2: f = 29366;
      3: f = 32963;
      4: f = 34923;
      5: f = 39200;
      6: f = 44000;
      default: f = 49388;
    endcase
    mid = (64'(CLK_HZ) * 100) / (2 * f);
    if (oct == 0) return int'(mid * 2);
    if (oct == 2) return int'(mid / 2);
    return int'(mid);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int note, input int oct, input logic en);
    note_in = 4'(note);
    octave  = 2'(oct);
    enable  = en;
  endtask

  // Measure n speaker level segments starting at the current negedge and
  // compare each length against the next scoreboard entry.
  task automatic collect(input int n, input string tag);
    logic level;
    int   len;
    int   expected;
    checkOutput({tag, " queue depth"}, exp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      level = speaker;
      len   = 0;
      while (speaker === level && len <= SEG_LIMIT) begin
        @(negedge clk);
        len++;
      end
      expected = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      checkOutput($sformatf("%s half %0d", tag, i), len, expected);
    end
  endtask

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    @(negedge clk);
    checkOutput("reset speaker", speaker, 0);
    checkOutput("reset playing", playing, 0);
    checkOutput("reset note_active", note_active, 0);
    reset = 1'b1;

`ifdef BUZZER_ENVELOPE_EN
    begin
      int highs;
      int waited;
      applyStimulus(6, 1, 1'b1);
      repeat (2) @(negedge clk);
      repeat (1030) @(negedge clk);
      highs = 0;
      repeat (2300) begin
        @(negedge clk);
        if (speaker) highs++;
      end
      checkOutput("env decayed high cycles", highs, 0);
      note_in = 4'd0;
      waited  = 0;
      while (playing && waited < 5000) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("env drained playing", playing, 0);
      applyStimulus(1, 1, 1'b1);
      repeat (2) @(negedge clk);
      highs = 0;
      repeat (8) begin
        if (speaker) highs++;
        @(negedge clk);
      end
      checkOutput("env restrike loud", highs >= 5, 1);
    end
`else
    // Enable low keeps the buzzer silent.
    applyStimulus(6, 1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("disabled playing", playing, 0);
    checkOutput("disabled speaker", speaker, 0);

    // Two cycles of latency from input change to the first rising edge.
    enable = 1'b1;
    @(negedge clk);
    checkOutput("latency 1 cycle speaker", speaker, 0);
    @(negedge clk);
    checkOutput("latency 2 cycles speaker", speaker, 1);
    checkOutput("la playing", playing, 1);
    checkOutput("la note_active", note_active, 6);
    exp_q.push_back(tbHalf(6, 1));
    exp_q.push_back(tbHalf(6, 1));
    collect(2, "la");

    // la -> sol mid-half: current half finishes at la length.
    exp_q.push_back(tbHalf(6, 1));
    exp_q.push_back(tbHalf(5, 1));
    exp_q.push_back(tbHalf(5, 1));
    fork
      collect(3, "la to sol");
      begin
        repeat (100) @(negedge clk);
        note_in = 4'd5;
      end
    join
    checkOutput("sol note_active", note_active, 5);

    // Low-octave do.
    exp_q.push_back(tbHalf(5, 1));
    exp_q.push_back(tbHalf(1, 0));
    exp_q.push_back(tbHalf(1, 0));
    fork
      collect(3, "do low");
      begin
        repeat (10) @(negedge clk);
        applyStimulus(1, 0, 1'b1);
      end
    join
    checkOutput("do low note_active", note_active, 1);

    // High-octave do.
    exp_q.push_back(tbHalf(1, 0));
    exp_q.push_back(tbHalf(1, 2));
    exp_q.push_back(tbHalf(1, 2));
    fork
      collect(3, "do high");
      begin
        repeat (10) @(negedge clk);
        octave = 2'd2;
      end
    join

    // Rest during a high half: the half completes, then silence.
    if (speaker == 1'b0) begin
      exp_q.push_back(tbHalf(1, 2));
      collect(1, "align");
    end
    exp_q.push_back(tbHalf(1, 2));
    fork
      collect(1, "rest drain");
      begin
        repeat (20) @(negedge clk);
        note_in = 4'd0;
      end
    join
    checkOutput("rest playing", playing, 0);
    checkOutput("rest note_active", note_active, 0);
    repeat (30) @(negedge clk);
    checkOutput("rest stays silent", speaker, 0);

    // Note code 9 behaves as rest.
    applyStimulus(3, 1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("mi start speaker", speaker, 1);
    exp_q.push_back(tbHalf(3, 1));
    fork
      collect(1, "note9 drain");
      begin
        repeat (5) @(negedge clk);
        note_in = 4'd9;
      end
    join
    checkOutput("note9 playing", playing, 0);
    repeat (20) @(negedge clk);
    checkOutput("note9 silent", speaker, 0);

    // Enable drop during a low half: DRAIN for one cycle, then IDLE.
    applyStimulus(2, 1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("re start speaker", speaker, 1);
    exp_q.push_back(tbHalf(2, 1));
    collect(1, "re");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("disable drain playing", playing, 1);
    @(negedge clk);
    checkOutput("disable idle playing", playing, 0);
    checkOutput("disable idle speaker", speaker, 0);

    // Asynchronous reset while speaker is high, then resume.
    applyStimulus(6, 1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset speaker", speaker, 1);
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset speaker", speaker, 0);
    checkOutput("async reset playing", playing, 0);
    checkOutput("async reset note_active", note_active, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("resume 1 cycle speaker", speaker, 0);
    @(negedge clk);
    checkOutput("resume 2 cycles speaker", speaker, 1);
    exp_q.push_back(tbHalf(6, 1));
    collect(1, "resume la");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
